sonar_uc: RTL and testbench
===========================

Name: sonar_uc

Overview:
- Control unit for the sonar datapath (sonar_fd).
- While `ligar` is high, runs a continuous sweep loop: zero the servo up/down counter, trigger a distance measurement, then transmit the 8-character frame "aaa,ddd#" serially.
- After the frame it waits the inter-position interval, steps the servo and repeats.
- Adds a measurement watchdog so a missing echo cannot hang the sweep.

Parameters:
- TIMEOUT_CICLOS, default 3_000_000: max cycles in ESPERA_MEDIDA before a measurement is abandoned (60 ms at 50 MHz).
- TIMEOUT_BITS, default 22: width of the internal watchdog counter; must satisfy 2^TIMEOUT_BITS > TIMEOUT_CICLOS.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- ligar  input  1  level; enables and sustains the sweep.
- fim_distancia  input  1  1-cycle pulse, measurement done.
- fim_transmissao  input  1  1-cycle pulse, character sent.
- fim_contador_serial  input  1  level, serial char counter = 7.
- fim_contador_intervalo  input  1  level, interval counter at terminal count.
- medir  output  1  measurement start pulse.
- transmitir  output  1  serial start pulse.
- conta_updown  output  1  servo position step.
- reset_updown  output  1  synchronous clear of the servo position counter.
- conta_serial  output  1  advance the character select counter.
- conta_intervalo  output  1  interval counter enable.
- pronto  output  1  1-cycle pulse after each complete frame.
- falha  output  1  sticky flag, watchdog expired at least once since last start.
- db_estado  output  4  current state code.

Behaviour:
- Moore FSM; every output is decoded from the state register only.
- On `reset` low (asynchronous): state INICIAL, watchdog = 0, `falha` = 0, all outputs 0.
- States, in the form code name: outputs -> transitions:
  - 0 INICIAL: none -> PREPARACAO if `ligar`, else stay.
  - 1 PREPARACAO: `reset_updown`=1; clears `falha` -> MEDIDA.
  - 2 MEDIDA: `medir`=1 (exactly 1 cycle); watchdog <= 0 -> ESPERA_MEDIDA.
  - 3 ESPERA_MEDIDA: watchdog +1 per cycle.
    - -> TRANSMISSAO on `fim_distancia`.
    - else -> ERRO_MEDIDA when watchdog == TIMEOUT_CICLOS-1.
    - `fim_distancia` wins if both occur in the same cycle.
  - 4 TRANSMISSAO: `transmitir`=1 (1 cycle) -> ESPERA_TX.
  - 5 ESPERA_TX: waits for `fim_transmissao`.
    - -> ULTIMO_CHAR if `fim_contador_serial`=1 in that cycle.
    - else -> PROXIMO_CHAR.
  - 6 PROXIMO_CHAR: `conta_serial`=1 -> TRANSMISSAO.
  - 7 ULTIMO_CHAR: `conta_serial`=1 (serial counter wraps 7->0); `pronto`=1 -> ESPERA_INTERVALO.
  - 8 ERRO_MEDIDA: sets `falha`; no transmission -> ESPERA_INTERVALO.
  - 9 ESPERA_INTERVALO: `conta_intervalo`=1 -> PROXIMA_POSICAO when `fim_contador_intervalo`.
    - `conta_intervalo` is still high in the exit cycle, so the interval counter wraps to 0.
  - 10 PROXIMA_POSICAO: `conta_updown`=1 (1 cycle) -> MEDIDA if `ligar`, else INICIAL.
- Unused codes 11-15 -> INICIAL on the next clock.
- Frame accounting: exactly 8 `transmitir` pulses and 8 `conta_serial` pulses per frame, so the serial counter is back at 0 for the next frame.
- `ligar` is sampled only in INICIAL and PROXIMA_POSICAO. Dropping it mid-frame completes the frame, the interval and the step, then parks in INICIAL.
- Watchdog saturates at TIMEOUT_CICLOS-1 and counts only in ESPERA_MEDIDA. A `fim_distancia` arriving outside ESPERA_MEDIDA is ignored.
- `fim_transmissao` outside ESPERA_TX is ignored.
- Asynchronous reset mid-frame aborts immediately. The datapath serial counter is not cleared by this block; the datapath shares the same reset.
- `db_estado` = state code above; `db_estado` = 0 in reset.

Test Plan:
- Reset low with `ligar`=1 -> `db_estado`=0 and all outputs 0. Release reset -> PREPARACAO: `reset_updown`=1 for 1 cycle; next cycle `medir`=1 for 1 cycle.
- Normal frame, TIMEOUT_CICLOS=50; `fim_distancia` 10 cycles after `medir`; `fim_transmissao` 5 cycles after each `transmitir`; model the serial counter -> 8 `transmitir` pulses, 8 `conta_serial` pulses, `pronto` once, then `conta_intervalo` high.
- Interval of 20 cycles ends -> one `conta_updown` pulse, then `medir` on the next cycle. Repeat for 9 positions; `falha`=0 throughout.
- No `fim_distancia` -> ERRO_MEDIDA exactly 50 cycles after MEDIDA; `falha`=1 and stays 1; zero `transmitir` pulses; interval then step proceed normally.
- `ligar` dropped during the 3rd character -> remaining 5 characters sent, interval and step completed, then `db_estado`=0 with no further `medir`. Raising `ligar` -> PREPARACAO clears `falha`.
- `fim_distancia` and watchdog expiry in the same cycle -> TRANSMISSAO taken, `falha` unchanged. Reset pulse during ESPERA_TX -> `db_estado`=0 immediately (asynchronous).

Source files
------------

// File: rtl/sonar_uc.sv
// Sonar sweep control unit: Moore FSM that sequences servo zeroing, measurement, 8-char serial frame, interval wait and servo step.
// Outputs are decoded from the state register (no combinational path from inputs); a watchdog abandons measurements whose echo never arrives.
module sonar_uc #(
  parameter int TIMEOUT_CICLOS = 3_000_000,
  parameter int TIMEOUT_BITS   = 22
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       fim_distancia,
  input  logic       fim_transmissao,
  input  logic       fim_contador_serial,
  input  logic       fim_contador_intervalo,
  output logic       medir,
  output logic       transmitir,
  output logic       conta_updown,
  output logic       reset_updown,
  output logic       conta_serial,
  output logic       conta_intervalo,
  output logic       pronto,
  output logic       falha,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL          = 4'd0,
    PREPARACAO       = 4'd1,
    MEDIDA           = 4'd2,
    ESPERA_MEDIDA    = 4'd3,
    TRANSMISSAO      = 4'd4,
    ESPERA_TX        = 4'd5,
    PROXIMO_CHAR     = 4'd6,
    ULTIMO_CHAR      = 4'd7,
    ERRO_MEDIDA      = 4'd8,
    ESPERA_INTERVALO = 4'd9,
    PROXIMA_POSICAO  = 4'd10
  } estado_t;

  localparam logic [TIMEOUT_BITS-1:0] WD_MAX = TIMEOUT_BITS'(TIMEOUT_CICLOS - 1);

  estado_t                 estado;
  estado_t                 proximo;
  logic [TIMEOUT_BITS-1:0] watchdog;
  logic                    wd_expirou;

  assign wd_expirou = (watchdog == WD_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
    end else begin
      estado <= proximo;
    end
  end

  // Watchdog only advances while waiting for the echo and holds at its terminal value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      watchdog <= '0;
      falha    <= 1'b0;
    end else begin
      if (estado == MEDIDA) begin
        watchdog <= '0;
      end else if (estado == ESPERA_MEDIDA && !wd_expirou) begin
        watchdog <= watchdog + 1'b1;
      end

      if (estado == PREPARACAO) begin
        falha <= 1'b0;
      end else if (estado == ERRO_MEDIDA) begin
        falha <= 1'b1;
      end
    end
  end

  always_comb begin
    proximo         = estado;
    medir           = 1'b0;
    transmitir      = 1'b0;
    conta_updown    = 1'b0;
    reset_updown    = 1'b0;
    conta_serial    = 1'b0;
    conta_intervalo = 1'b0;
    pronto          = 1'b0;

    case (estado)
      INICIAL: begin
        if (ligar) proximo = PREPARACAO;
      end
      PREPARACAO: begin
        reset_updown = 1'b1;
        proximo      = MEDIDA;
      end
      MEDIDA: begin
        medir   = 1'b1;
        proximo = ESPERA_MEDIDA;
      end
      ESPERA_MEDIDA: begin
        // A real echo takes priority over a watchdog expiry in the same cycle.
        if (fim_distancia)   proximo = TRANSMISSAO;
        else if (wd_expirou) proximo = ERRO_MEDIDA;
      end
      TRANSMISSAO: begin
        transmitir = 1'b1;
        proximo    = ESPERA_TX;
      end
      ESPERA_TX: begin
        if (fim_transmissao) begin
          proximo = fim_contador_serial ? ULTIMO_CHAR : PROXIMO_CHAR;
        end
      end
      PROXIMO_CHAR: begin
        conta_serial = 1'b1;
        proximo      = TRANSMISSAO;
      end
      ULTIMO_CHAR: begin
        conta_serial = 1'b1;
        pronto       = 1'b1;
        proximo      = ESPERA_INTERVALO;
      end
      ERRO_MEDIDA: begin
        proximo = ESPERA_INTERVALO;
      end
      ESPERA_INTERVALO: begin
        conta_intervalo = 1'b1;
        if (fim_contador_intervalo) proximo = PROXIMA_POSICAO;
      end
      PROXIMA_POSICAO: begin
        conta_updown = 1'b1;
        proximo      = ligar ? MEDIDA : INICIAL;
      end
      default: begin
        proximo = INICIAL;
      end
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_sonar_uc.sv
// Bench for sonar_uc: behavioural datapath model plus a per-frame scoreboard of expected pulse counts.
module tb_sonar_uc;

  localparam int TMO     = 50;
  localparam int TX_LAT  = 5;
  localparam int INT_LEN = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ligar = 1'b0;
  logic       fim_distancia = 1'b0;
  logic       fim_transmissao = 1'b0;
  logic       fim_contador_serial = 1'b0;
  logic       fim_contador_intervalo = 1'b0;
  logic       medir, transmitir, conta_updown, reset_updown;
  logic       conta_serial, conta_intervalo, pronto, falha;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int   tx;
    int   cs;
    int   pr;
    logic falha;
    int   pos;
  } exp_t;
  exp_t sb[$];

  int   dist_delay = 10;
  int   ser_cnt, int_cnt, pos, tx_cnt, dist_cnt;
  logic p_cs, p_ci, p_cu, p_ru;
  int   n_tx, n_cs, n_pronto, n_cu, n_medir;
  int   esp_len, last_esp_len, frames_done, exp_pos;
  logic exp_falha;
  logic [3:0] prev_st;

  sonar_uc #(.TIMEOUT_CICLOS(TMO), .TIMEOUT_BITS(6)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .ligar                  (ligar),
    .fim_distancia          (fim_distancia),
    .fim_transmissao        (fim_transmissao),
    .fim_contador_serial    (fim_contador_serial),
    .fim_contador_intervalo (fim_contador_intervalo),
    .medir                  (medir),
    .transmitir             (transmitir),
    .conta_updown           (conta_updown),
    .reset_updown           (reset_updown),
    .conta_serial           (conta_serial),
    .conta_intervalo        (conta_intervalo),
    .pronto                 (pronto),
    .falha                  (falha),
    .db_estado              (db_estado)
  );

  always #5 clock = ~clock;

  // Datapath model, responders and scoreboard; runs 1 time unit after each rising edge.
  initial begin : model
    exp_t e;
    frames_done = 0;
    n_medir     = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        ser_cnt = 0; int_cnt = 0; pos = 0; tx_cnt = 0; dist_cnt = 0;
        p_cs = 0; p_ci = 0; p_cu = 0; p_ru = 0;
        prev_st = 4'd0; exp_falha = 1'b0; exp_pos = 0;
        esp_len = 0; last_esp_len = 0;
        sb.delete();
        fim_distancia = 0; fim_transmissao = 0;
        fim_contador_serial = 0; fim_contador_intervalo = 0;
      end else begin
        if (p_ru)      pos = 0;
        else if (p_cu) pos = pos + 1;
        if (p_cs) ser_cnt = (ser_cnt + 1) % 8;
        if (p_ci) int_cnt = (int_cnt == INT_LEN - 1) ? 0 : int_cnt + 1;
        fim_contador_serial    = (ser_cnt == 7);
        fim_contador_intervalo = (int_cnt == INT_LEN - 1);

        fim_transmissao = 1'b0;
        if (tx_cnt > 0) begin
          tx_cnt = tx_cnt - 1;
          if (tx_cnt == 0) fim_transmissao = 1'b1;
        end
        if (transmitir) tx_cnt = TX_LAT;

        fim_distancia = 1'b0;
        if (dist_cnt > 0) begin
          dist_cnt = dist_cnt - 1;
          if (dist_cnt == 0) fim_distancia = 1'b1;
        end

        if (reset_updown) begin
          exp_falha = 1'b0;
          exp_pos   = 0;
        end

        if (medir) begin
          n_tx = 0; n_cs = 0; n_pronto = 0; n_cu = 0; esp_len = 0;
          n_medir = n_medir + 1;
          if (dist_delay > 0) dist_cnt = dist_delay;
          if (dist_delay > 0 && dist_delay <= TMO) begin
            e.tx = 8; e.cs = 8; e.pr = 1;
          end else begin
            e.tx = 0; e.cs = 0; e.pr = 0;
            exp_falha = 1'b1;
          end
          e.falha = exp_falha;
          e.pos   = exp_pos;
          exp_pos = exp_pos + 1;
          sb.push_back(e);
        end

        n_tx     = n_tx + int'(transmitir);
        n_cs     = n_cs + int'(conta_serial);
        n_pronto = n_pronto + int'(pronto);
        n_cu     = n_cu + int'(conta_updown);

        if (db_estado == 4'd3) esp_len = esp_len + 1;
        else if (prev_st == 4'd3) last_esp_len = esp_len;

        if (db_estado == 4'd9 && prev_st != 4'd9) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: frame ended with no expected entry");
          end else begin
            e = sb.pop_front();
            checks++;
            if (n_tx !== e.tx) begin errors++; $display("FAIL frame_tx: got %0d want %0d", n_tx, e.tx); end
            checks++;
            if (n_cs !== e.cs) begin errors++; $display("FAIL frame_cs: got %0d want %0d", n_cs, e.cs); end
            checks++;
            if (n_pronto !== e.pr) begin errors++; $display("FAIL frame_pronto: got %0d want %0d", n_pronto, e.pr); end
            checks++;
            if (falha !== e.falha) begin errors++; $display("FAIL frame_falha: got %b want %b", falha, e.falha); end
            checks++;
            if (pos !== e.pos) begin errors++; $display("FAIL frame_pos: got %0d want %0d", pos, e.pos); end
            frames_done = frames_done + 1;
          end
        end

        p_cs = conta_serial; p_ci = conta_intervalo;
        p_cu = conta_updown; p_ru = reset_updown;
        prev_st = db_estado;
      end
    end
  end

  task automatic wait_state(input logic [3:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock);
      #2;
      if (db_estado == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; ligar = 1'b1; dist_delay = 10;
    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL rst_estado: got %0d want 0", db_estado); end
    checks++;
    if ({medir, transmitir, conta_updown, reset_updown, conta_serial, conta_intervalo, pronto, falha} !== 8'h00) begin
      errors++; $display("FAIL rst_outputs: got %b want 00000000",
        {medir, transmitir, conta_updown, reset_updown, conta_serial, conta_intervalo, pronto, falha});
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #2;
    checks++;
    if (db_estado !== 4'd1 || reset_updown !== 1'b1 || medir !== 1'b0) begin
      errors++; $display("FAIL prep: estado=%0d reset_updown=%b medir=%b want 1/1/0", db_estado, reset_updown, medir);
    end
    @(posedge clock); #2;
    checks++;
    if (db_estado !== 4'd2 || medir !== 1'b1 || reset_updown !== 1'b0) begin
      errors++; $display("FAIL medida: estado=%0d medir=%b reset_updown=%b want 2/1/0", db_estado, medir, reset_updown);
    end
    @(posedge clock); #2;
    checks++;
    if (db_estado !== 4'd3 || medir !== 1'b0) begin
      errors++; $display("FAIL medir_pulse: estado=%0d medir=%b want 3/0", db_estado, medir);
    end
  endtask

  task automatic test_sweep;
    bit ok = 1'b0;
    bit falha_seen = 1'b0;
    bit prev_cu = 1'b0;
    int bad_adj = 0;
    int steps = 0;
    int run = 0;
    int bad_int = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clock); #2;
      if (falha) falha_seen = 1'b1;
      if (prev_cu) begin
        steps++;
        if (medir !== 1'b1) bad_adj++;
      end
      prev_cu = conta_updown;
      if (conta_intervalo) run++;
      else if (run > 0) begin
        if (run != INT_LEN) bad_int++;
        run = 0;
      end
      if (frames_done >= 9) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL sweep_timeout: frames=%0d want 9", frames_done); end
    checks++;
    if (falha_seen) begin errors++; $display("FAIL sweep_falha: got 1 want 0"); end
    checks++;
    if (steps != 8 || bad_adj != 0) begin
      errors++; $display("FAIL sweep_step: steps=%0d bad_adjacent=%0d want 8/0", steps, bad_adj);
    end
    checks++;
    if (bad_int != 0) begin errors++; $display("FAIL sweep_interval: bad intervals=%0d want 0", bad_int); end
  endtask

  task automatic test_timeout;
    bit ok;
    dist_delay = 0;
    wait_state(4'd8, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tmo_reach: ERRO_MEDIDA not reached, estado=%0d", db_estado); end
    checks++;
    if (last_esp_len !== TMO) begin errors++; $display("FAIL tmo_len: got %0d want %0d", last_esp_len, TMO); end
    dist_delay = 10;
    @(posedge clock); #2;
    checks++;
    if (falha !== 1'b1 || db_estado !== 4'd9) begin
      errors++; $display("FAIL tmo_falha: falha=%b estado=%0d want 1/9", falha, db_estado);
    end
    wait_state(4'd2, 200, ok);
    checks++;
    if (!ok || falha !== 1'b1) begin errors++; $display("FAIL tmo_sticky: ok=%b falha=%b want 1/1", ok, falha); end
  endtask

  task automatic test_coincide;
    bit ok;
    dist_delay = TMO;
    wait_state(4'd2, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL coin_medir: no medir, estado=%0d", db_estado); end
    wait_state(4'd4, 100, ok);
    checks++;
    if (!ok || last_esp_len !== TMO) begin
      errors++; $display("FAIL coin_tx: ok=%b wait_len=%0d want 1/%0d", ok, last_esp_len, TMO);
    end
    checks++;
    if (falha !== 1'b1) begin errors++; $display("FAIL coin_falha: got %b want 1", falha); end
  endtask

  task automatic test_ligar_drop;
    bit ok;
    int m;
    dist_delay = 10;
    wait_state(4'd2, 300, ok);
    for (int i = 0; i < 200 && n_tx < 3; i++) begin
      @(posedge clock); #2;
    end
    ligar = 1'b0;
    checks++;
    if (!ok || n_tx !== 3) begin errors++; $display("FAIL drop_start: ok=%b n_tx=%0d want 1/3", ok, n_tx); end
    wait_state(4'd0, 400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_park: INICIAL not reached, estado=%0d", db_estado); end
    checks++;
    if (n_tx !== 8 || n_cs !== 8 || n_pronto !== 1 || n_cu !== 1) begin
      errors++; $display("FAIL drop_counts: tx=%0d cs=%0d pronto=%0d step=%0d want 8/8/1/1", n_tx, n_cs, n_pronto, n_cu);
    end
    m = n_medir;
    repeat (30) @(posedge clock);
    #2;
    checks++;
    if (n_medir !== m || db_estado !== 4'd0) begin
      errors++; $display("FAIL drop_idle: medir_count=%0d estado=%0d want %0d/0", n_medir, db_estado, m);
    end
    checks++;
    if (falha !== 1'b1) begin errors++; $display("FAIL drop_falha_held: got %b want 1", falha); end
    ligar = 1'b1;
    wait_state(4'd1, 5, ok);
    @(posedge clock); #2;
    checks++;
    if (!ok || falha !== 1'b0 || medir !== 1'b1) begin
      errors++; $display("FAIL restart_clear: ok=%b falha=%b medir=%b want 1/0/1", ok, falha, medir);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    wait_state(4'd5, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_reach: ESPERA_TX not reached, estado=%0d", db_estado); end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (db_estado !== 4'd0 || {medir, transmitir, conta_serial, pronto} !== 4'b0000) begin
      errors++; $display("FAIL rmid_async: estado=%0d outs=%b want 0/0000", db_estado, {medir, transmitir, conta_serial, pronto});
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    wait_state(4'd2, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_restart: MEDIDA not reached, estado=%0d", db_estado); end
  endtask

  initial begin
    test_reset;
    test_sweep;
    test_timeout;
    test_coincide;
    test_ligar_drop;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
